onchip_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single-port 4096×32 on-chip RAM between two masters, such as the CPU data port and the SDRAM-test DMA engine. It grants one transfer per clock using round-robin priority, drives the RAM's single port, and returns read data with a fixed one-cycle latency tagged to the requester that issued the read. It sits directly in front of the on-chip memory and gives each master a pipelined Avalon-MM slave port with `waitrequest` and `readdatavalid`.

---
 rtl/onchip_mem_arbiter_if.sv | 57 +++++
 rtl/onchip_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle for the two-master on-chip RAM arbiter.
// Contents: both Avalon-MM slave ports (m0_*, m1_*) and the RAM single port (mem_*).
// Modports:
//   slave  - the arbiter side
//   master - the environment: the two masters plus the RAM
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
      output mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
      input  mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters.
//
// Behaviour:
//   - One transfer is granted per clock.
//   - Grant and waitrequest are combinational from the current requests and the
//     registered last-granted pointer.
//   - Read data returns one cycle after the grant, tagged to the issuing master.
//
// Conventions used below:
//   - last = 1 means master 1 was served last.
//   - Reset assertion is asynchronous.
//   - Reset release is delayed by two flops, so the RAM clock enable and grants
//     start on the second rising edge after reset_n rises.
module onchip_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   onchip_mem_arbiter_if.slave  bus
);
   localparam int BE_W = DATA_W / 8;

   logic [1:0]        rst_sync;
   logic              run;

   logic              req0;
   logic              req1;
   logic              gnt0;
   logic              gnt1;
   logic              gnt_any;
   logic              last;

   logic              sel_write;
   logic              sel_read;
   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;

   logic [ADDR_W-1:0] hold_address;
   logic [BE_W-1:0]   hold_byteenable;
   logic [DATA_W-1:0] hold_writedata;

   logic              rd_pend;
   logic              rd_id;

   // Two-flop release of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

   assign req0 = bus.m0_read | bus.m0_write;
   assign req1 = bus.m1_read | bus.m1_write;

   // Round-robin grant: under contention, the master not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (run) begin
         if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign gnt_any = gnt0 | gnt1;

   // Steer the granted master onto the RAM port.
   // A write beats a simultaneous read from the same master, so the RAM is never
   // given an ambiguous command.
   // With no grant, the port replays its previous address/data to avoid toggling.
   always_comb begin
      sel_address    = hold_address;
      sel_byteenable = hold_byteenable;
      sel_writedata  = hold_writedata;
      sel_write      = 1'b0;
      sel_read       = 1'b0;
      if (gnt0) begin
         sel_address    = bus.m0_address;
         sel_byteenable = bus.m0_byteenable;
         sel_writedata  = bus.m0_writedata;
         sel_write      = bus.m0_write;
         sel_read       = bus.m0_read & ~bus.m0_write;
      end else if (gnt1) begin
         sel_address    = bus.m1_address;
         sel_byteenable = bus.m1_byteenable;
         sel_writedata  = bus.m1_writedata;
         sel_write      = bus.m1_write;
         sel_read       = bus.m1_read & ~bus.m1_write;
      end
   end

   // Remember the last values driven onto the RAM port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_address    <= '0;
         hold_byteenable <= '0;
         hold_writedata  <= '0;
      end else begin
         hold_address    <= sel_address;
         hold_byteenable <= sel_byteenable;
         hold_writedata  <= sel_writedata;
      end
   end

   // Track the last granted master.
   // Resets to 1 so that master 0 wins the first contention.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= 1'b1;
      end else if (gnt0) begin
         last <= 1'b0;
      end else if (gnt1) begin
         last <= 1'b1;
      end
   end

   // One-deep read return tag, matching the RAM's one-cycle read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_id   <= 1'b0;
      end else begin
         rd_pend <= sel_read;
         rd_id   <= gnt1;
      end
   end

   assign bus.mem_address    = sel_address;
   assign bus.mem_byteenable = sel_byteenable;
   assign bus.mem_writedata  = sel_writedata;
   assign bus.mem_chipselect = gnt_any;
   assign bus.mem_write      = sel_write;
   assign bus.mem_clken      = run;

   assign bus.m0_waitrequest = req0 & ~gnt0;
   assign bus.m1_waitrequest = req1 & ~gnt1;

   assign bus.m0_readdata      = bus.mem_readdata;
   assign bus.m1_readdata      = bus.mem_readdata;
   assign bus.m0_readdatavalid = rd_pend & ~rd_id;
   assign bus.m1_readdatavalid = rd_pend & rd_id;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter.
//
// Environment:
//   - A RAM model with a one-cycle registered read drives mem_readdata.
//
// Checking:
//   - A transaction-level reference (winner choice, reference memory image,
//     pending read) is checked against every DUT output on each falling edge.
//   - Directed scenarios add literal expectations.
module tb_onchip_mem_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int a);
      return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM model ----------------
   // Address and write are registered; read data is the old word.
   // Port values are captured on the falling edge, so the rising edge sees the
   // pre-edge values.
   logic [31:0] ram [4096];
   logic [31:0] ram_q = 32'h0;
   logic        cap_en = 1'b0;
   logic        cap_cs = 1'b0;
   logic        cap_wr = 1'b0;
   logic [11:0] cap_addr = 12'h0;
   logic [3:0]  cap_be = 4'h0;
   logic [31:0] cap_wd = 32'h0;

   always @(negedge clk) begin
      cap_en   = bus.mem_clken;
      cap_cs   = bus.mem_chipselect;
      cap_wr   = bus.mem_write;
      cap_addr = bus.mem_address;
      cap_be   = bus.mem_byteenable;
      cap_wd   = bus.mem_writedata;
   end

   always @(posedge clk) begin
      if (cap_en && reset_n) begin
         ram_q <= ram[cap_addr];
         if (cap_cs && cap_wr) begin
            for (int b = 0; b < 4; b++)
               if (cap_be[b]) ram[cap_addr][8*b +: 8] = cap_wd[8*b +: 8];
         end
      end
   end

   assign bus.mem_readdata = ram_q;

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [4096];
   bit          m_last      = 1'b1;
   int          m_edges     = 0;
   bit          m_pend      = 1'b0;
   bit          m_pend_id   = 1'b0;
   logic [31:0] m_pend_data = 32'h0;
   logic [11:0] m_hold_addr = 12'h0;
   logic [3:0]  m_hold_be   = 4'h0;
   logic [31:0] m_hold_wd   = 32'h0;
   bit          st_g  = 1'b0;
   bit          st_id = 1'b0;
   bit          st_wr = 1'b0;
   bit          st_rd = 1'b0;
   logic [11:0] st_addr = 12'h0;
   logic [3:0]  st_be = 4'h0;
   logic [31:0] st_wd = 32'h0;

   always @(negedge reset_n) begin
      m_last      = 1'b1;
      m_edges     = 0;
      m_pend      = 1'b0;
      m_hold_addr = 12'h0;
      m_hold_be   = 4'h0;
      m_hold_wd   = 32'h0;
      st_g        = 1'b0;
   end

   always @(posedge clk) begin
      if (reset_n) begin
         if (m_edges < 2) m_edges++;
         m_pend    = st_g && st_rd;
         m_pend_id = st_id;
         if (st_g) begin
            m_pend_data = ref_mem[st_addr];
            m_last      = st_id;
            m_hold_addr = st_addr;
            m_hold_be   = st_be;
            m_hold_wd   = st_wd;
            if (st_wr) begin
               for (int b = 0; b < 4; b++)
                  if (st_be[b]) ref_mem[st_addr][8*b +: 8] = st_wd[8*b +: 8];
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output against the reference.
   always @(negedge clk) begin
      bit          run;
      bit          rq0;
      bit          rq1;
      bit          wr;
      bit          rd;
      int          winner;
      logic [11:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      run    = reset_n && (m_edges >= 2);
      rq0    = bus.m0_read || bus.m0_write;
      rq1    = bus.m1_read || bus.m1_write;
      winner = -1;
      if (run) begin
         if (rq0 && rq1) winner = m_last ? 0 : 1;
         else if (rq0)   winner = 0;
         else if (rq1)   winner = 1;
      end
      a  = m_hold_addr;
      be = m_hold_be;
      wd = m_hold_wd;
      wr = 1'b0;
      rd = 1'b0;
      if (winner == 0) begin
         a  = bus.m0_address;
         be = bus.m0_byteenable;
         wd = bus.m0_writedata;
         wr = bus.m0_write;
         rd = bus.m0_read && !bus.m0_write;
      end else if (winner == 1) begin
         a  = bus.m1_address;
         be = bus.m1_byteenable;
         wd = bus.m1_writedata;
         wr = bus.m1_write;
         rd = bus.m1_read && !bus.m1_write;
      end
      chk("cmp_m0_waitrequest", 32'(bus.m0_waitrequest), 32'(rq0 && winner != 0));
      chk("cmp_m1_waitrequest", 32'(bus.m1_waitrequest), 32'(rq1 && winner != 1));
      chk("cmp_mem_chipselect", 32'(bus.mem_chipselect), 32'(winner >= 0));
      chk("cmp_mem_write", 32'(bus.mem_write), 32'(wr));
      chk("cmp_mem_clken", 32'(bus.mem_clken), 32'(run));
      chk("cmp_mem_address", 32'(bus.mem_address), 32'(a));
      chk("cmp_mem_byteenable", 32'(bus.mem_byteenable), 32'(be));
      chk("cmp_mem_writedata", bus.mem_writedata, wd);
      chk("cmp_m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(m_pend && !m_pend_id));
      chk("cmp_m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(m_pend && m_pend_id));
      if (m_pend && !m_pend_id) chk("cmp_m0_readdata", bus.m0_readdata, m_pend_data);
      if (m_pend && m_pend_id)  chk("cmp_m1_readdata", bus.m1_readdata, m_pend_data);
      st_g    = (winner >= 0);
      st_id   = (winner == 1);
      st_wr   = wr;
      st_rd   = rd;
      st_addr = a;
      st_be   = be;
      st_wd   = wd;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_m0(bit r, bit w, logic [11:0] a, logic [3:0] be, logic [31:0] d);
      bus.m0_read       = r;
      bus.m0_write      = w;
      bus.m0_address    = a;
      bus.m0_byteenable = be;
      bus.m0_writedata  = d;
   endtask

   task automatic set_m1(bit r, bit w, logic [11:0] a, logic [3:0] be, logic [31:0] d);
      bus.m1_read       = r;
      bus.m1_write      = w;
      bus.m1_address    = a;
      bus.m1_byteenable = be;
      bus.m1_writedata  = d;
   endtask

   task automatic idle();
      set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // Call with reset asserted.
   // Both masters read, reset is released, and the bench checks that nothing is
   // granted until the second edge, where master 0 wins.
   task automatic release_check(string tag);
      set_m0(1'b1, 1'b0, 12'h000, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 12'hFFF, 4'hF, 32'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_edge1_chipselect"}, 32'(bus.mem_chipselect), 32'd0);
      chk({tag, "_edge1_clken"}, 32'(bus.mem_clken), 32'd0);
      chk({tag, "_edge1_m0_wait"}, 32'(bus.m0_waitrequest), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_edge2_chipselect"}, 32'(bus.mem_chipselect), 32'd1);
      chk({tag, "_edge2_clken"}, 32'(bus.mem_clken), 32'd1);
      chk({tag, "_edge2_m0_wait"}, 32'(bus.m0_waitrequest), 32'd0);
      chk({tag, "_edge2_m1_wait"}, 32'(bus.m1_waitrequest), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = init_word(i);
         ref_mem[i] = init_word(i);
      end
      idle();
      #1 reset_n = 1'b0;

      // Reset held while the masters issue random requests.
      for (int i = 0; i < 4; i++) begin
         step();
         set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                4'($urandom_range(0, 15)), $urandom);
         set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                4'($urandom_range(0, 15)), $urandom);
         look();
         chk("rst_m0_valid", 32'(bus.m0_readdatavalid), 32'd0);
         chk("rst_m1_valid", 32'(bus.m1_readdatavalid), 32'd0);
         chk("rst_chipselect", 32'(bus.mem_chipselect), 32'd0);
         chk("rst_clken", 32'(bus.mem_clken), 32'd0);
         chk("rst_address", 32'(bus.mem_address), 32'd0);
      end
      release_check("rst");

      // Continuous contention: cycle 0 went to m0 above; grants alternate from there.
      for (int k = 1; k < 9; k++) begin
         step();
         if (k == 8) idle();
         look();
         if (k < 8) begin
            chk("rr_m0_wait", 32'(bus.m0_waitrequest), 32'(k % 2));
            chk("rr_m1_wait", 32'(bus.m1_waitrequest), 32'(1 - (k % 2)));
         end
         chk("rr_m0_valid", 32'(bus.m0_readdatavalid), 32'(((k - 1) % 2) == 0));
         chk("rr_m1_valid", 32'(bus.m1_readdatavalid), 32'(((k - 1) % 2) == 1));
         if (((k - 1) % 2) == 0) chk("rr_m0_data", bus.m0_readdata, init_word(0));
         else                    chk("rr_m1_data", bus.m1_readdata, init_word(12'hFFF));
      end

      // Single master write then read.
      step();
      set_m0(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);
      look();
      chk("wr_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
      step();
      set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      look();
      chk("rd_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
      step();
      idle();
      look();
      chk("rd_m0_valid", 32'(bus.m0_readdatavalid), 32'd1);
      chk("rd_m0_data", bus.m0_readdata, 32'hDEAD_BEEF);
      chk("rd_m1_valid", 32'(bus.m1_readdatavalid), 32'd0);

      // Byte lanes.
      step();
      set_m0(1'b0, 1'b1, 12'h020, 4'hF, 32'h1122_3344);
      step();
      set_m0(1'b0, 1'b1, 12'h020, 4'h2, 32'hAAAA_AAAA);
      step();
      set_m0(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
      step();
      idle();
      look();
      chk("be_m0_valid", 32'(bus.m0_readdatavalid), 32'd1);
      chk("be_m0_data", bus.m0_readdata, 32'h1122_AA44);

      // Read followed by a write to the same word from the other master.
      step();
      set_m0(1'b1, 1'b0, 12'h100, 4'hF, 32'h0);
      look();
      chk("ilv_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
      step();
      set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_m1(1'b0, 1'b1, 12'h100, 4'hF, 32'h0BAD_F00D);
      look();
      chk("ilv_m1_wait", 32'(bus.m1_waitrequest), 32'd0);
      chk("ilv_m0_valid", 32'(bus.m0_readdatavalid), 32'd1);
      chk("ilv_m0_old", bus.m0_readdata, init_word(12'h100));
      step();
      idle();
      set_m0(1'b1, 1'b0, 12'h100, 4'hF, 32'h0);
      step();
      idle();
      look();
      chk("ilv_m0_new", bus.m0_readdata, 32'h0BAD_F00D);

      // Reset in the middle of an m1 read.
      step();
      set_m1(1'b1, 1'b0, 12'h055, 4'hF, 32'h0);
      look();
      chk("mid_m1_wait", 32'(bus.m1_waitrequest), 32'd0);
      #2 reset_n = 1'b0;
      step();
      look();
      chk("mid_m1_valid", 32'(bus.m1_readdatavalid), 32'd0);
      chk("mid_clken", 32'(bus.mem_clken), 32'd0);
      release_check("mid");

      // Random traffic on a small address window, including an illegal read+write
      // and a reset in the middle of the run.
      for (int i = 0; i < 600; i++) begin
         step();
         if (i == 300) reset_n = 1'b0;
         if (i == 303) reset_n = 1'b1;
         set_m0(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 12'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom);
         set_m1(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 12'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom);
      end
      step();
      idle();
      for (int i = 0; i < 4; i++) step();
      look();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
